// File: rtl/merlin_imem_responder_if.sv
// Instruction-bus request/response bundle between the pre-fetch unit (master)
// and the instruction memory responder (slave).
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

interface merlin_imem_responder_if;
  logic                ireqready_o;
  logic                ireqvalid_i;
  logic [1:0]          ireqhpl_i;
  logic [`RV_XLEN-1:0] ireqaddr_i;
  logic                irspready_i;
  logic                irspvalid_o;
  logic                irsprerr_o;
  logic [`RV_XLEN-1:0] irspdata_o;

  modport master (
    input  ireqready_o,
    output ireqvalid_i,
    output ireqhpl_i,
    output ireqaddr_i,
    output irspready_i,
    input  irspvalid_o,
    input  irsprerr_o,
    input  irspdata_o
  );

  modport slave (
    output ireqready_o,
    input  ireqvalid_i,
    input  ireqhpl_i,
    input  ireqaddr_i,
    input  irspready_i,
    output irspvalid_o,
    output irsprerr_o,
    output irspdata_o
  );
endinterface

// File: rtl/merlin_imem_responder.sv
// Instruction memory responder: word RAM, fixed-latency read pipeline and a
// credit-guarded response FIFO. Optional privilege check: MERLIN_IMEM_HPL_CHECK_EN.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

module merlin_imem_responder #(
  parameter int                  C_ADDR_WORDS_X = 10,
  parameter logic [`RV_XLEN-1:0] C_MEM_BASE     = 32'h0000_0000,
  parameter int                  C_READ_LATENCY = 1,
  parameter int                  C_RSP_DEPTH_X  = 2,
  parameter logic [`RV_XLEN-1:0] C_USER_BASE    = 32'h0000_1000
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  merlin_imem_responder_if.slave    ibus,
  input  logic                      ldwr_i,
  input  logic [C_ADDR_WORDS_X-1:0] ldaddr_i,
  input  logic [`RV_XLEN-1:0]       lddata_i
);

  localparam int XW        = `RV_XLEN;
  localparam int AW        = C_ADDR_WORDS_X;
  localparam int DX        = C_RSP_DEPTH_X;
  localparam int RAM_WORDS = 1 << AW;
  localparam int RSP_DEPTH = 1 << DX;

  localparam logic [XW:0] RAM_BYTES  = (XW+1)'(RAM_WORDS) << 2;
  localparam logic [DX:0] CREDIT_MAX = (DX+1)'(RSP_DEPTH);

  logic          accept;
  logic          deliver;
  logic [DX:0]   credits;
  logic [XW-1:0] offset;
  logic          in_range;
  logic          fetch_ok;
  logic [AW-1:0] index;

  logic          vld_p0;
  logic          rerr_p0;
  logic [XW-1:0] ram_p0;
  logic [XW-1:0] data_s0;

  logic          tail_vld;
  logic          tail_rerr;
  logic [XW-1:0] tail_data;

  logic [XW-1:0] mem [RAM_WORDS];

  logic [DX:0]   wr_ptr;
  logic [DX:0]   rd_ptr;
  logic          fifo_empty;
  logic [XW:0]   fifo_mem [RSP_DEPTH];
  logic [XW:0]   head;

  assign accept  = ibus.ireqvalid_i & ibus.ireqready_o;
  assign deliver = ibus.irspvalid_o & ibus.irspready_i;

  // Free slots = buffer depth minus everything in the pipeline or the buffer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits <= CREDIT_MAX;
    end else if (accept & ~deliver) begin
      credits <= credits - 1'b1;
    end else if (~accept & deliver) begin
      credits <= credits + 1'b1;
    end
  end

  assign ibus.ireqready_o = |credits;

  assign offset   = ibus.ireqaddr_i - C_MEM_BASE;
  assign in_range = ({1'b0, offset} < RAM_BYTES);
  assign index    = ibus.ireqaddr_i[AW+1:2];

`ifdef MERLIN_IMEM_HPL_CHECK_EN
  assign fetch_ok = in_range &
                    ~((ibus.ireqhpl_i == 2'b00) && (ibus.ireqaddr_i < C_USER_BASE));
`else
  logic [XW+1:0] hpl_unused;
  assign hpl_unused = {ibus.ireqhpl_i, C_USER_BASE};
  assign fetch_ok   = in_range;
`endif

  // ---- stage 0: request accepted, RAM read registered ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
    end
  end

  always_ff @(posedge clk_i) begin
    rerr_p0 <= ~fetch_ok;
  end

  // Read-before-write: a fetch colliding with a loader write sees the old word.
  always_ff @(posedge clk_i) begin
    if (accept & fetch_ok) begin
      ram_p0 <= mem[index];
    end
    if (ldwr_i) begin
      mem[ldaddr_i] <= lddata_i;
    end
  end

  assign data_s0 = rerr_p0 ? '0 : ram_p0;

  // ---- stages 1..C_READ_LATENCY-1: pure delay line ----
  generate
    if (C_READ_LATENCY == 1) begin : g_lat1
      assign tail_vld  = vld_p0;
      assign tail_rerr = rerr_p0;
      assign tail_data = data_s0;
    end else begin : g_latn
      logic          vld_pn  [1:C_READ_LATENCY-1];
      logic          rerr_pn [1:C_READ_LATENCY-1];
      logic [XW-1:0] data_pn [1:C_READ_LATENCY-1];

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          for (int i = 1; i < C_READ_LATENCY; i++) begin
            vld_pn[i] <= 1'b0;
          end
        end else begin
          vld_pn[1] <= vld_p0;
          for (int i = 2; i < C_READ_LATENCY; i++) begin
            vld_pn[i] <= vld_pn[i-1];
          end
        end
      end

      always_ff @(posedge clk_i) begin
        rerr_pn[1] <= rerr_p0;
        data_pn[1] <= data_s0;
        for (int i = 2; i < C_READ_LATENCY; i++) begin
          rerr_pn[i] <= rerr_pn[i-1];
          data_pn[i] <= data_pn[i-1];
        end
      end

      assign tail_vld  = vld_pn[C_READ_LATENCY-1];
      assign tail_rerr = rerr_pn[C_READ_LATENCY-1];
      assign tail_data = data_pn[C_READ_LATENCY-1];
    end
  endgenerate

  // ---- response buffer: never overflows thanks to the credit counter ----
  assign fifo_empty = (wr_ptr == rd_ptr);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (tail_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deliver) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (tail_vld) begin
      fifo_mem[wr_ptr[DX-1:0]] <= {tail_rerr, tail_data};
    end
  end

  assign head = fifo_mem[rd_ptr[DX-1:0]];

  assign ibus.irspvalid_o = ~fifo_empty;
  assign ibus.irsprerr_o  = ~fifo_empty & head[XW];
  assign ibus.irspdata_o  = fifo_empty ? '0 : head[XW-1:0];

endmodule

// File: tb/tb_merlin_imem_responder.sv
// Randomised bench for merlin_imem_responder against a queue-based response model.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

module tb_merlin_imem_responder;

`ifdef MERLIN_IMEM_HPL_CHECK_EN
  localparam int AW = 11;
`else
  localparam int AW = 10;
`endif
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam logic [31:0] USER_BASE = 32'h0000_1000;
  localparam int          LAT       = 1;
  localparam int          DEPTH     = 4;
  localparam int          RAM_WORDS = 1 << AW;
  localparam logic [63:0] RAM_BYTES = 64'(RAM_WORDS) * 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          ldwr_i;
  logic [AW-1:0] ldaddr_i;
  logic [31:0]   lddata_i;

  merlin_imem_responder_if ibus();

  merlin_imem_responder #(
    .C_ADDR_WORDS_X (AW),
    .C_MEM_BASE     (BASE),
    .C_READ_LATENCY (LAT),
    .C_RSP_DEPTH_X  (2),
    .C_USER_BASE    (USER_BASE)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .ibus     (ibus),
    .ldwr_i   (ldwr_i),
    .ldaddr_i (ldaddr_i),
    .lddata_i (lddata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    logic        rerr;
    logic [31:0] data;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] mram [RAM_WORDS];
  logic [31:0] log_data[$];
  logic        log_rerr[$];
  int          log_cyc[$];
  int          acc_cyc[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic ent_t model_fetch(input logic [31:0] addr, input logic [1:0] hpl, input int now);
    ent_t        e;
    logic [63:0] off;
    logic        ok;
    off = {32'h0, addr - BASE};
    ok  = (off < RAM_BYTES);
`ifdef MERLIN_IMEM_HPL_CHECK_EN
    if (hpl == 2'b00 && addr < USER_BASE) ok = 1'b0;
`else
    if (hpl == 2'b11 && 1'b0) ok = 1'b0;
`endif
    e.due  = now + LAT + 1;
    e.rerr = ~ok;
    e.data = ok ? mram[addr[AW+1:2]] : 32'h0;
    return e;
  endfunction

  // Cycle-by-cycle comparison against the model, sampled at the falling edge.
  always @(negedge clk_i) begin
    logic exp_ready, exp_valid, acc, dlv;
    if (reset_i) begin
      chk("rst_ready", 32'(ibus.ireqready_o), 32'd1);
      chk("rst_valid", 32'(ibus.irspvalid_o), 32'd0);
      chk("rst_rerr",  32'(ibus.irsprerr_o),  32'd0);
      chk("rst_data",  ibus.irspdata_o,       32'd0);
      exp_q.delete();
    end else begin
      exp_ready = (exp_q.size() < DEPTH);
      exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      chk("ready", 32'(ibus.ireqready_o), 32'(exp_ready));
      chk("valid", 32'(ibus.irspvalid_o), 32'(exp_valid));
      if (exp_valid) begin
        chk("rerr", 32'(ibus.irsprerr_o), 32'(exp_q[0].rerr));
        chk("data", ibus.irspdata_o,      exp_q[0].data);
      end
      acc = ibus.ireqvalid_i & exp_ready;
      dlv = exp_valid & ibus.irspready_i;
      if (dlv) begin
        log_data.push_back(ibus.irspdata_o);
        log_rerr.push_back(ibus.irsprerr_o);
        log_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(model_fetch(ibus.ireqaddr_i, ibus.ireqhpl_i, cyc));
        acc_cyc.push_back(cyc);
      end
      if (ldwr_i) mram[ldaddr_i] = lddata_i;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr);
    ibus.ireqvalid_i = 1'b1;
    ibus.ireqaddr_i  = addr;
    step();
    ibus.ireqvalid_i = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    ldwr_i   = 1'b1;
    ldaddr_i = AW'(a);
    lddata_i = d;
    step();
    ldwr_i   = 1'b0;
  endtask

  initial begin
    int          n0, a0;
    logic [31:0] lit [4];
    lit[0] = 32'h11; lit[1] = 32'h22; lit[2] = 32'h33; lit[3] = 32'h44;

    reset_i          = 1'b1;
    ldwr_i           = 1'b0;
    ldaddr_i         = '0;
    lddata_i         = '0;
    ibus.ireqvalid_i = 1'b0;
    ibus.ireqhpl_i   = 2'b11;
    ibus.ireqaddr_i  = '0;
    ibus.irspready_i = 1'b1;
    repeat (3) step();
    reset_i = 1'b0;
    step();
    chk("reset_ready_lit", 32'(ibus.ireqready_o), 32'd1);
    chk("reset_valid_lit", 32'(ibus.irspvalid_o), 32'd0);

    for (int i = 0; i < RAM_WORDS; i++) load(i, $urandom);
    for (int i = 0; i < 4; i++) load(i, lit[i]);
    load(5, 32'h55);
    load(RAM_WORDS - 1, 32'hCAFE);
    load(512, 32'h512);
    if (RAM_WORDS > 1024) load(1024, 32'h1024);

    // Back-to-back fetches with the initiator always ready.
    n0 = log_data.size(); a0 = acc_cyc.size();
    for (int i = 0; i < 4; i++) begin
      ibus.ireqvalid_i = 1'b1;
      ibus.ireqaddr_i  = 32'(i * 4);
      step();
    end
    ibus.ireqvalid_i = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 4; i++) chk("b2b_data_lit", log_data[n0+i], lit[i]);
    chk("b2b_rerr_lit", 32'(log_rerr[n0]), 32'd0);
    chk("first_latency_lit", 32'(log_cyc[n0] - acc_cyc[a0]), 32'd2);

    // Stall responses: exactly DEPTH requests get in.
    ibus.irspready_i = 1'b0;
    n0 = log_data.size(); a0 = acc_cyc.size();
    for (int i = 0; i < 8; i++) begin
      ibus.ireqvalid_i = 1'b1;
      ibus.ireqaddr_i  = 32'((i % 4) * 4);
      step();
    end
    ibus.ireqvalid_i = 1'b0;
    chk("full_accepts_lit", 32'(acc_cyc.size() - a0), 32'd4);
    chk("full_ready_lit", 32'(ibus.ireqready_o), 32'd0);
    ibus.irspready_i = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 4; i++) chk("drain_data_lit", log_data[n0+i], lit[i]);
    chk("drain_ready_lit", 32'(ibus.ireqready_o), 32'd1);

    // Range boundary.
    n0 = log_data.size();
    fetch(RAM_BYTES[31:0]);
    fetch(RAM_BYTES[31:0] - 32'd4);
    repeat (5) step();
    chk("oor_rerr_lit", 32'(log_rerr[n0]), 32'd1);
    chk("oor_data_lit", log_data[n0], 32'd0);
    chk("top_rerr_lit", 32'(log_rerr[n0+1]), 32'd0);
    chk("top_data_lit", log_data[n0+1], 32'hCAFE);

    // Loader write colliding with a fetch of the same word.
    n0 = log_data.size();
    ldwr_i = 1'b1; ldaddr_i = AW'(5); lddata_i = 32'hDEAD;
    fetch(32'h14);
    ldwr_i = 1'b0;
    fetch(32'h14);
    repeat (5) step();
    chk("collide_old_lit", log_data[n0], 32'h55);
    chk("collide_new_lit", log_data[n0+1], 32'hDEAD);

    // Reset with responses pending.
    ibus.irspready_i = 1'b0;
    for (int i = 0; i < 3; i++) fetch(32'(i * 4));
    repeat (3) step();
    n0 = log_data.size();
    reset_i = 1'b1;
    #1;
    chk("midrst_valid_lit", 32'(ibus.irspvalid_o), 32'd0);
    chk("midrst_ready_lit", 32'(ibus.ireqready_o), 32'd1);
    step();
    step();
    reset_i = 1'b0;
    ibus.irspready_i = 1'b1;
    repeat (6) step();
    chk("midrst_no_stale_lit", 32'(log_data.size() - n0), 32'd0);

`ifdef MERLIN_IMEM_HPL_CHECK_EN
    n0 = log_data.size();
    ibus.ireqhpl_i = 2'b00; fetch(32'h800);
    ibus.ireqhpl_i = 2'b11; fetch(32'h800);
    ibus.ireqhpl_i = 2'b00; fetch(32'h1000);
    ibus.ireqhpl_i = 2'b11;
    repeat (5) step();
    chk("hpl_user_low_rerr_lit", 32'(log_rerr[n0]), 32'd1);
    chk("hpl_user_low_data_lit", log_data[n0], 32'd0);
    chk("hpl_mach_data_lit", log_data[n0+1], 32'h512);
    chk("hpl_user_ok_data_lit", log_data[n0+2], 32'h1024);
`endif

    // Randomised traffic with loader writes and back-pressure.
    for (int i = 0; i < 1500; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 5)       a = 32'($urandom_range(0, 15)) << 2;
      else if (r < 7)  a = 32'($urandom_range(0, RAM_WORDS - 1)) << 2;
      else if (r == 7) a = RAM_BYTES[31:0] + (32'($urandom_range(0, 3)) << 2);
      else if (r == 8) a = $urandom;
      else             a = 32'hFFFF_FFFC;
      a[1:0] = 2'($urandom_range(0, 3));
      ibus.ireqvalid_i = ($urandom_range(0, 3) != 0);
      ibus.ireqaddr_i  = a;
      ibus.ireqhpl_i   = 2'($urandom_range(0, 3));
      ibus.irspready_i = ($urandom_range(0, 3) != 0);
      ldwr_i   = ($urandom_range(0, 5) == 0);
      ldaddr_i = AW'($urandom_range(0, 15));
      lddata_i = $urandom;
      step();
    end
    ibus.ireqvalid_i = 1'b0;
    ldwr_i = 1'b0;
    ibus.irspready_i = 1'b1;
    repeat (10) step();
    chk("final_idle_valid", 32'(ibus.irspvalid_o), 32'd0);
    chk("final_idle_ready", 32'(ibus.ireqready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/merlin_imem_responder.md
Name: merlin_imem_responder

Overview:
- Responder end of the instruction-bus protocol used by the pre-fetch unit: accepts word fetch requests and returns read data or an error with a fixed, parameterised latency.
- Contains a dual-port word RAM, a read-latency pipeline and a credit-controlled response buffer.
- Because of the response buffer, the initiator may keep requests in flight and may stall responses without any data being lost.
- Sits between the core's ibus and on-chip instruction memory; a side write port lets the loader or testbench fill the RAM.

Parameters:
- C_ADDR_WORDS_X, 10, log2 of RAM size in 32-bit words (default 1024 words).
- C_MEM_BASE, 32'h0000_0000, byte base address of the RAM; must be aligned to the RAM size.
- C_READ_LATENCY, 1, cycles from request accept to response entering the buffer; legal range 1..4.
- C_RSP_DEPTH_X, 2, log2 of response buffer depth; requires 2^C_RSP_DEPTH_X >= C_READ_LATENCY+1.
- C_USER_BASE, 32'h0000_1000, lowest byte address fetchable at hpl 2'b00 (used only when the optional feature is enabled).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- ireqready_o  out  1  request accepted this cycle when high together with ireqvalid_i.
- ireqvalid_i  in  1  request valid.
- ireqhpl_i  in  2  privilege level of the request.
- ireqaddr_i  in  `RV_XLEN  byte address; bits [1:0] are ignored.
- irspready_i  in  1  initiator ready for a response.
- irspvalid_o  out  1  response valid.
- irsprerr_o  out  1  response carries a bus error.
- irspdata_o  out  `RV_XLEN  read data.
- ldwr_i  in  1  loader write strobe.
- ldaddr_i  in  C_ADDR_WORDS_X  loader word address.
- lddata_i  in  `RV_XLEN  loader write data.

Behaviour:
- Reset values:
  - ireqready_o=1, irspvalid_o=0, irsprerr_o=0, irspdata_o=0.
  - Credit counter = 2^C_RSP_DEPTH_X.
  - Pipeline valid bits cleared; response buffer empty.
  - RAM contents are not reset.
- Credit counter (C_RSP_DEPTH_X+1 bits):
  - accept = ireqvalid_i & ireqready_o; deliver = irspvalid_o & irspready_i.
  - accept & ~deliver: decrement. ~accept & deliver: increment. Both or neither: hold.
  - ireqready_o = (credits != 0), registered-free combinational decode of the counter only; it does not depend on ireqvalid_i.
- Address decode at accept:
  - In range when (ireqaddr_i - C_MEM_BASE) < 4*2^C_ADDR_WORDS_X, compared unsigned.
  - Word index = ireqaddr_i[C_ADDR_WORDS_X+1:2].
  - Out of range: rerr=1 and data=0; the RAM is not read.
- Pipeline:
  - Stage 0 registers {valid, rerr, index}; the RAM read completes by stage C_READ_LATENCY.
  - The entry is written into the response buffer exactly C_READ_LATENCY cycles after accept.
  - The pipeline never stalls; the credit scheme guarantees buffer space.
- Response buffer:
  - FIFO of {rerr, data}; irspvalid_o = ~empty; head is presented on irsprerr_o/irspdata_o.
  - Pop on deliver. irspdata_o is held stable while irspvalid_o & ~irspready_i.
  - Back-to-back accepts are allowed every cycle while credits remain.
- Ordering: responses are returned strictly in request order.
- Pass-through:
  - When the buffer is empty and an entry arrives, irspvalid_o rises the cycle after the entry is written; it is never combinational from ireqvalid_i.
  - Minimum request-to-response latency is therefore C_READ_LATENCY+1 cycles.
- Loader port: ldwr_i writes lddata_i to RAM[ldaddr_i] on the clock edge. A same-cycle fetch of the same word returns the old data.
- Full boundary: at credits==0, ireqready_o=0. A deliver in that cycle restores ireqready_o=1 on the next cycle.
- Reset mid-operation: all in-flight and buffered responses are discarded and credits are restored immediately.

Optional Feature:
- Macro: MERLIN_IMEM_HPL_CHECK_EN.
- Defined: an in-range request with ireqhpl_i==2'b00 and ireqaddr_i < C_USER_BASE gets rerr=1 and data=0, with the same latency as a normal read.
- Undefined: ireqhpl_i is ignored, and C_USER_BASE has no effect.

Test Plan:
- Load RAM[0..3] = 32'h11,22,33,44. Issue addresses 0x0,0x4,0x8,0xC back-to-back with irspready_i=1 -> responses 0x11,0x22,0x33,0x44 in order, rerr=0, first response 2 cycles after accept (latency 1).
- Hold irspready_i=0 and issue requests -> exactly 4 accepted, then ireqready_o=0. Release ready -> 4 responses in order, then ireqready_o=1.
- Request address 0x0000_1000 with 10-bit RAM -> rerr=1, data=0. Address 0x0000_0FFC -> rerr=0.
- Loader writes 0xDEAD to word 5 in the same cycle as a fetch of 0x14 -> fetch returns the old value; the next fetch returns 0xDEAD.
- Assert reset with 3 responses pending -> irspvalid_o=0 and ireqready_o=1 immediately; no stale response is ever seen afterwards.
- With MERLIN_IMEM_HPL_CHECK_EN: hpl=0 at 0x800 -> rerr=1; hpl=3 at 0x800 -> data returned; hpl=0 at 0x1000 -> data returned.
